stopwatch_ctrl: RTL

- Front-panel controller that sequences the stopwatch counter from two raw push-buttons.
- Synchronises and debounces both buttons, runs the run/stop/lap/clear state machine, and drives run-enable and clear into the stopwatch.
- Freezes the displayed time in lap mode while the counter keeps running.
- Sits between the board buttons and the stopwatch's 24-bit time output on one side, and the display path on the other.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/btn_debounce.sv | 50 +++++
 rtl/stopwatch_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - state encoding and default widths shared by the stopwatch front panel
package stopwatch_pkg;

   localparam int TIME_W_DEF = 24;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      STOPPED = 2'd2,
      LAP     = 2'd3
   } sw_state_t;

   function automatic logic is_counting(input sw_state_t s);
      return (s == RUNNING) || (s == LAP);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, stable-level debouncer and registered press pulse
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_level_q;
   logic             r_press;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_level_q <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         // Any cycle where the synchronised input agrees with the level restarts the run.
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         r_level_q <= r_level;
         r_press   <= r_level & ~r_level_q;
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/stop/lap/clear sequencer with lap freeze; long-press clear under STOPWATCH_CTRL_LONGPRESS_EN
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TIME_W          = TIME_W_DEF,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 200000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_start,
   input  logic              btn_lap,
   input  logic [TIME_W-1:0] sw_time,
   output logic              sw_run,
   output logic              sw_clear,
   output logic [TIME_W-1:0] disp_time,
   output logic              lap_active,
   output logic [1:0]        state
);

   logic w_start_press;
   logic w_start_level;
   logic w_lap_press;
   logic w_lap_level;
   logic w_long_fire;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (btn_start),
      .o_level (w_start_level),
      .o_press (w_start_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (btn_lap),
      .o_level (w_lap_level),
      .o_press (w_lap_press)
   );

`ifdef STOPWATCH_CTRL_LONGPRESS_EN
   localparam int LONG_W = $clog2(LONG_CYCLES + 1);
   localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);
   localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

   logic [LONG_W-1:0] r_long_cnt;

   // Saturating at LONG_CYCLES keeps the fire condition true for one cycle per hold.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_long_cnt <= '0;
      end else if (!w_lap_level) begin
         r_long_cnt <= '0;
      end else if (r_long_cnt != LONG_SAT) begin
         r_long_cnt <= r_long_cnt + LONG_W'(1);
      end
   end

   assign w_long_fire = w_lap_level && (r_long_cnt == LONG_LAST);
`else
   assign w_long_fire = 1'b0;
`endif

   sw_state_t         r_state;
   sw_state_t         w_state_nxt;
   logic              r_clear;
   logic              w_clear_nxt;
   logic [TIME_W-1:0] r_lap;
   logic              w_lap_capture;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_clear <= 1'b0;
         r_lap   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_clear <= w_clear_nxt;
         if (w_lap_capture) begin
            r_lap <= sw_time;
         end
      end
   end

   // Start has priority; a lap pulse arriving with it is dropped.
   always_comb begin
      w_state_nxt   = r_state;
      w_clear_nxt   = 1'b0;
      w_lap_capture = 1'b0;
      if (w_long_fire) begin
         w_state_nxt = IDLE;
         w_clear_nxt = 1'b1;
      end else if (w_start_press) begin
         case (r_state)
            IDLE:    w_state_nxt = RUNNING;
            RUNNING: w_state_nxt = STOPPED;
            STOPPED: w_state_nxt = RUNNING;
            LAP:     w_state_nxt = STOPPED;
            default: w_state_nxt = IDLE;
         endcase
      end else if (w_lap_press) begin
         case (r_state)
            IDLE:    w_state_nxt = IDLE;
            RUNNING: begin
               w_state_nxt   = LAP;
               w_lap_capture = 1'b1;
            end
            STOPPED: begin
               w_state_nxt = IDLE;
               w_clear_nxt = 1'b1;
            end
            LAP:     w_state_nxt = RUNNING;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign state      = r_state;
   assign sw_run     = is_counting(r_state);
   assign sw_clear   = r_clear;
   assign lap_active = (r_state == LAP);
   assign disp_time  = lap_active ? r_lap : sw_time;

endmodule
